// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the synchronous FIFO controller.
//   DEFAULT_ADDR_WIDTH : default RAM address width (DEPTH = 1 << ADDR_WIDTH)
//   err_t              : sticky error flags {overflow, underflow}
//   err_update()       : next-state of the sticky error flags
package fifo_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

    // A new error event wins over a same-cycle clear.
    function automatic err_t err_update(err_t cur, logic set_ov, logic set_un, logic clr);
        err_t nxt;
        nxt.overflow  = set_ov | (cur.overflow  & ~clr);
        nxt.underflow = set_un | (cur.underflow & ~clr);
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle between the FIFO users and sync_fifo_ctrl.
//   master : producer/consumer side, drives flush/winc/rinc/clr_err
//   slave  : controller side, drives RAM controls, flags, count, rvalid, errors
interface sync_fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  flush;
    logic                  winc;
    logic                  rinc;
    logic                  clr_err;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  wclken;
    logic                  rclken;
    logic                  wfull;
    logic                  rempty;
    logic                  walmost_full;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  rvalid;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, winc, rinc, clr_err,
        input  waddr, raddr, wclken, rclken, wfull, rempty, walmost_full, ralmost_empty,
        input  count, rvalid, overflow, underflow
    );

    modport slave (
        input  flush, winc, rinc, clr_err,
        output waddr, raddr, wclken, rclken, wfull, rempty, walmost_full, ralmost_empty,
        output count, rvalid, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr_ctr.sv
// Binary FIFO pointer with wrap bit.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset (pointer -> 0)
//   i_clear : synchronous clear, higher priority than i_inc
//   i_inc   : advance pointer by one
//   o_ptr   : current pointer (MSB is the wrap bit)
module fifo_ptr_ctr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock pointer/flag controller driving a dual-port RAM as a synchronous FIFO.
//   i_clk : clock (RAM write and read clocks tie to this)
//   i_rst : asynchronous active-high reset
//   bus   : slave side of sync_fifo_ctrl_if
//           in : flush, winc, rinc, clr_err
//           out: waddr, raddr, wclken, rclken, wfull, rempty, walmost_full, ralmost_empty,
//                count, rvalid, overflow, underflow
module sync_fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    sync_fifo_ctrl_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sync_fifo_ctrl: levels must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [CW-1:0] w_wptr;
    logic [CW-1:0] w_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_set_ov;
    logic          w_set_un;
    logic          r_rvalid;
    err_t          r_err;
    err_t          w_err_next;

    // Flags come from the registered count only, so winc/rinc never reach a flag combinationally.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    assign w_push_ok = bus.winc & ~w_full  & ~bus.flush;
    assign w_pop_ok  = bus.rinc & ~w_empty & ~bus.flush;
    assign w_set_ov  = bus.winc &  w_full  & ~bus.flush;
    assign w_set_un  = bus.rinc &  w_empty & ~bus.flush;

    fifo_ptr_ctr #(
        .WIDTH (CW)
    ) u_wptr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (bus.flush),
        .i_inc   (w_push_ok),
        .o_ptr   (w_wptr)
    );

    fifo_ptr_ctr #(
        .WIDTH (CW)
    ) u_rptr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (bus.flush),
        .i_inc   (w_pop_ok),
        .o_ptr   (w_rptr)
    );

    always_comb begin
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = '0;
        end else begin
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    assign w_err_next = err_update(r_err, w_set_ov, w_set_un, bus.clr_err);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= '0;
        end else begin
            r_count  <= w_count_next;
            // pop_ok already excludes flush, so a flush also drops rvalid.
            r_rvalid <= w_pop_ok;
            r_err    <= w_err_next;
        end
    end

    assign bus.waddr         = w_wptr[ADDR_WIDTH-1:0];
    assign bus.raddr         = w_rptr[ADDR_WIDTH-1:0];
    assign bus.wclken        = w_push_ok;
    assign bus.rclken        = w_pop_ok;
    assign bus.wfull         = w_full;
    assign bus.rempty        = w_empty;
    assign bus.walmost_full  = (r_count >= LP_AF);
    assign bus.ralmost_empty = (r_count <= LP_AE);
    assign bus.count         = r_count;
    assign bus.rvalid        = r_rvalid;
    assign bus.overflow      = r_err.overflow;
    assign bus.underflow     = r_err.underflow;

    // The wrap-bit pointer difference must always equal the occupancy count.
    logic [CW-1:0] w_ptr_diff;
    assign w_ptr_diff = w_wptr - w_rptr;

    ap_count_matches_ptrs : assert property (
        @(posedge i_clk) disable iff (i_rst) (r_count == w_ptr_diff)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a behavioural RAM and a data scoreboard.
module tb_sync_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    sync_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // Behavioural stand-in for fifomem: sync write, registered read, rdata=0 when not reading.
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] mem [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (bus.wclken) mem[bus.waddr] <= wdata;
            rdata <= bus.rclken ? mem[bus.raddr] : 8'h00;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int         m_count;
    int         m_wptr;
    int         m_rptr;
    int         m_next_data;
    bit         m_ov;
    bit         m_un;
    bit         m_rvalid;
    logic [7:0] m_rd;
    logic [7:0] sb_q [$];

    typedef struct {
        bit f;
        bit w;
        bit r;
        bit c;
        int cnt;
        bit ov;
        bit un;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_wptr   = 0;
        m_rptr   = 0;
        m_ov     = 0;
        m_un     = 0;
        m_rvalid = 0;
        m_rd     = 8'h00;
        sb_q.delete();
    endtask

    task automatic check_all();
        chk("count", 32'(bus.count), 32'(m_count));
        chk("wfull", 32'(bus.wfull), 32'(m_count == DEPTH));
        chk("rempty", 32'(bus.rempty), 32'(m_count == 0));
        chk("walmost_full", 32'(bus.walmost_full), 32'(m_count >= AF));
        chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(m_count <= AE));
        chk("overflow", 32'(bus.overflow), 32'(m_ov));
        chk("underflow", 32'(bus.underflow), 32'(m_un));
        chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        if (m_rvalid) chk("rdata", 32'(rdata), 32'(m_rd));
        chk("wclken", 32'(bus.wclken),
            32'(bus.winc && (m_count < DEPTH) && !bus.flush));
        chk("rclken", 32'(bus.rclken),
            32'(bus.rinc && (m_count > 0) && !bus.flush));
        chk("waddr", 32'(bus.waddr), 32'(m_wptr));
        chk("raddr", 32'(bus.raddr), 32'(m_rptr));
    endtask

    // Drive one cycle at negedge, check outputs before the edge, advance the model at the edge.
    task automatic step(input bit f, input bit w, input bit r, input bit c);
        bit push;
        bit pop;
        @(negedge clk);
        bus.flush   = f;
        bus.winc    = w;
        bus.rinc    = r;
        bus.clr_err = c;
        wdata       = 8'(m_next_data);
        #1;
        check_all();
        @(posedge clk);
        push = w && (m_count < DEPTH) && !f;
        pop  = r && (m_count > 0) && !f;
        if (w && (m_count == DEPTH) && !f) m_ov = 1;
        else if (c) m_ov = 0;
        if (r && (m_count == 0) && !f) m_un = 1;
        else if (c) m_un = 0;
        if (f) begin
            m_count = 0;
            m_wptr  = 0;
            m_rptr  = 0;
            sb_q.delete();
        end else begin
            if (push) begin
                sb_q.push_back(8'(m_next_data));
                m_wptr = (m_wptr + 1) % DEPTH;
                m_next_data++;
            end
            if (pop) begin
                m_rd   = sb_q.pop_front();
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            m_count = m_count + int'(push) - int'(pop);
        end
        m_rvalid = pop;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.winc    = 1'b0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.winc    = 1'b0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        wdata       = 8'h00;
        m_next_data = 0;
        model_reset();

        tbl[0]  = '{f:0, w:1, r:1, c:0, cnt:1, ov:0, un:1};
        tbl[1]  = '{f:0, w:0, r:0, c:1, cnt:1, ov:0, un:0};
        tbl[2]  = '{f:0, w:1, r:0, c:0, cnt:2, ov:0, un:0};
        tbl[3]  = '{f:0, w:1, r:1, c:0, cnt:2, ov:0, un:0};
        tbl[4]  = '{f:0, w:0, r:1, c:0, cnt:1, ov:0, un:0};
        tbl[5]  = '{f:0, w:0, r:1, c:0, cnt:0, ov:0, un:0};
        tbl[6]  = '{f:0, w:0, r:1, c:0, cnt:0, ov:0, un:1};
        tbl[7]  = '{f:0, w:1, r:0, c:1, cnt:1, ov:0, un:0};
        tbl[8]  = '{f:1, w:1, r:1, c:0, cnt:0, ov:0, un:0};
        tbl[9]  = '{f:0, w:0, r:1, c:1, cnt:0, ov:0, un:1};
        tbl[10] = '{f:0, w:0, r:0, c:1, cnt:0, ov:0, un:0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);

        // Short table of single-cycle vectors from empty.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].c);
            #2;
            chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ov", i), 32'(bus.overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_un", i), 32'(bus.underflow), 32'(tbl[i].un));
        end

        // Fill 0x00..0x0F, then push once more while full.
        do_reset();
        m_next_data = 0;
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #2;
        chk("fill_wfull", 32'(bus.wfull), 32'd1);
        chk("fill_overflow", 32'(bus.overflow), 32'd1);

        // Drain in order, then pop once more while empty.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        #2;
        chk("drain_rempty", 32'(bus.rempty), 32'd1);
        chk("drain_underflow", 32'(bus.underflow), 32'd1);

        // Simultaneous push/pop at full, empty and mid-level.
        step(0, 0, 0, 1);
        while (m_count < DEPTH) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        #2;
        chk("simul_full_count", 32'(bus.count), 32'd15);
        while (m_count > 0) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        #2;
        chk("simul_empty_count", 32'(bus.count), 32'd1);
        while (m_count < 8) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        #2;
        chk("simul_mid_count", 32'(bus.count), 32'd8);

        // Steady-state streaming at count 5 across several address wraps.
        while (m_count > 5) step(0, 0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0);
        #2;
        chk("wrap_count", 32'(bus.count), 32'd5);

        // Flush at count 9 with push and pop requested.
        step(0, 0, 0, 1);
        while (m_count < 9) step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        #2;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_rvalid", 32'(bus.rvalid), 32'd0);
        chk("flush_no_err", 32'({bus.overflow, bus.underflow}), 32'd0);

        // Error clear, and clear colliding with a fresh overflow.
        while (m_count < DEPTH) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        #2;
        chk("clr_err_overflow", 32'(bus.overflow), 32'd0);
        step(0, 1, 0, 1);
        #2;
        chk("clr_vs_set_overflow", 32'(bus.overflow), 32'd1);

        // Reset mid-burst with a read in flight and an error pending.
        step(0, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
